wavetable_reader: RTL and testbench

Wavetable oscillator stage fed by the table-select PIO: consumes the 4-bit table index on that PIO's `out_port` and a phase increment, and on each sample-rate strobe fetches two adjacent samples from the wavetable ROM. It linearly interpolates between them and presents one signed 16-bit sample to the audio output path. The table index is applied only at phase-accumulator wrap, so waveform changes never cause a mid-period discontinuity.

---
 rtl/wavetable_reader_if.sv | 31 +++
 rtl/wavetable_reader.sv | 168 ++++++++++++++++
 tb/tb_wavetable_reader.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wavetable_reader_if.sv
// Wavetable reader bus bundle: table select, phase increment, sample strobe,
// wavetable ROM read port and audio sample output.
//   master : environment side (drives table_idx/phase_inc/sample_tick/rom_rdata)
//   slave  : wavetable_reader side (drives rom_rd/rom_addr/sample_*/busy/tick_overrun)
interface wavetable_reader_if #(
    parameter int unsigned PHASE_W  = 24,
    parameter int unsigned TABLE_AW = 8,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned SAMPLE_W = 16
);
    logic [IDX_W-1:0]          table_idx;
    logic [PHASE_W-1:0]        phase_inc;
    logic                      sample_tick;
    logic                      rom_rd;
    logic [IDX_W+TABLE_AW-1:0] rom_addr;
    logic [SAMPLE_W-1:0]       rom_rdata;
    logic [SAMPLE_W-1:0]       sample_out;
    logic                      sample_valid;
    logic                      busy;
    logic                      tick_overrun;

    modport master (
        output table_idx, phase_inc, sample_tick, rom_rdata,
        input  rom_rd, rom_addr, sample_out, sample_valid, busy, tick_overrun
    );

    modport slave (
        input  table_idx, phase_inc, sample_tick, rom_rdata,
        output rom_rd, rom_addr, sample_out, sample_valid, busy, tick_overrun
    );
endinterface

// File: rtl/wavetable_reader.sv
// Wavetable oscillator: on each sample tick fetches two adjacent samples of the
// current table from ROM, linearly interpolates by the phase fraction and
// presents one signed sample. Table changes take effect only at phase wrap.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : table_idx, phase_inc, sample_tick in; rom_rd/rom_addr out,
//                  rom_rdata in (ROM_LAT cycles after rom_rd); sample_out,
//                  sample_valid, busy, tick_overrun out (all registered)
module wavetable_reader #(
    parameter int unsigned PHASE_W  = 24,
    parameter int unsigned TABLE_AW = 8,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned ROM_LAT  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    wavetable_reader_if.slave bus
);
    localparam int unsigned FRAC_W = 8;
    localparam int unsigned ADDR_W = IDX_W + TABLE_AW;
    localparam int unsigned DIFF_W = SAMPLE_W + 1;
    localparam int unsigned PROD_W = DIFF_W + FRAC_W + 1;
    localparam int unsigned CNT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH0,
        S_WAIT0,
        S_FETCH1,
        S_WAIT1,
        S_OUTPUT
    } state_e;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            wait_cnt_q, wait_cnt_d;
    logic [PHASE_W-1:0]          phase_q, phase_d;
    logic [IDX_W-1:0]            table_cur_q, table_cur_d;
    logic signed [SAMPLE_W-1:0]  s0_q, s0_d;
    logic                        rom_rd_q, rom_rd_d;
    logic [ADDR_W-1:0]           rom_addr_q, rom_addr_d;
    logic [SAMPLE_W-1:0]         sample_out_q, sample_out_d;
    logic                        sample_valid_q, sample_valid_d;
    logic                        busy_q, busy_d;
    logic                        tick_overrun_q, tick_overrun_d;

    logic [TABLE_AW-1:0]         idx_c;
    logic [FRAC_W-1:0]           frac_c;
    logic [ADDR_W-1:0]           addr0_c, addr1_c;
    logic [PHASE_W:0]            phase_sum_c;
    logic signed [DIFF_W-1:0]    diff_c;
    logic signed [PROD_W-1:0]    prod_c;
    logic signed [SAMPLE_W-1:0]  interp_c;
    logic                        wait_done_c;

    // Address generation, phase advance and interpolation datapath
    always_comb begin
        idx_c       = phase_q[PHASE_W-1 -: TABLE_AW];
        frac_c      = phase_q[PHASE_W-TABLE_AW-1 -: FRAC_W];
        addr0_c     = {table_cur_q, idx_c};
        // second tap wraps within the current table
        addr1_c     = {table_cur_q, TABLE_AW'(idx_c + TABLE_AW'(1))};
        phase_sum_c = (PHASE_W+1)'(phase_q) + (PHASE_W+1)'(bus.phase_inc);
        diff_c      = DIFF_W'($signed(bus.rom_rdata)) - DIFF_W'(s0_q);
        prod_c      = PROD_W'(diff_c) * PROD_W'($signed({1'b0, frac_c}));
        // arithmetic shift floors; result stays between s0 and s1
        interp_c    = SAMPLE_W'(PROD_W'(s0_q) + (prod_c >>> FRAC_W));
        wait_done_c = (wait_cnt_q == CNT_W'(ROM_LAT - 1));
    end

    // Sequencer next state and registered outputs
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        phase_d        = phase_q;
        table_cur_d    = table_cur_q;
        s0_d           = s0_q;
        rom_rd_d       = 1'b0;
        rom_addr_d     = rom_addr_q;
        sample_out_d   = sample_out_q;
        sample_valid_d = 1'b0;
        tick_overrun_d = bus.sample_tick && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (bus.sample_tick) begin
                    state_d    = S_FETCH0;
                    rom_rd_d   = 1'b1;
                    rom_addr_d = addr0_c;
                end
            end
            S_FETCH0: begin
                state_d    = S_WAIT0;
                wait_cnt_d = '0;
            end
            S_WAIT0: begin
                if (wait_done_c) begin
                    s0_d       = $signed(bus.rom_rdata);
                    state_d    = S_FETCH1;
                    rom_rd_d   = 1'b1;
                    rom_addr_d = addr1_c;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_FETCH1: begin
                state_d    = S_WAIT1;
                wait_cnt_d = '0;
            end
            S_WAIT1: begin
                // s1 is consumed straight off the ROM bus
                if (wait_done_c) begin
                    sample_out_d   = interp_c;
                    sample_valid_d = 1'b1;
                    state_d        = S_OUTPUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_OUTPUT: begin
                state_d = S_IDLE;
                phase_d = phase_sum_c[PHASE_W-1:0];
                if (phase_sum_c[PHASE_W]) begin
                    table_cur_d = bus.table_idx;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            wait_cnt_q     <= '0;
            phase_q        <= '0;
            table_cur_q    <= '0;
            s0_q           <= '0;
            rom_rd_q       <= 1'b0;
            rom_addr_q     <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            tick_overrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            phase_q        <= phase_d;
            table_cur_q    <= table_cur_d;
            s0_q           <= s0_d;
            rom_rd_q       <= rom_rd_d;
            rom_addr_q     <= rom_addr_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            tick_overrun_q <= tick_overrun_d;
        end
    end

    assign bus.rom_rd       = rom_rd_q;
    assign bus.rom_addr     = rom_addr_q;
    assign bus.sample_out   = sample_out_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.busy         = busy_q;
    assign bus.tick_overrun = tick_overrun_q;
endmodule

// File: tb/tb_wavetable_reader.sv
// Testbench for wavetable_reader: ROM model with fixed read latency, and a
// reference oscillator model (phase/table/interpolation in plain arithmetic).
module tb_wavetable_reader;
    localparam int unsigned PHASE_W  = 24;
    localparam int unsigned TABLE_AW = 8;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned ROM_LAT  = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    wavetable_reader_if #(
        .PHASE_W(PHASE_W), .TABLE_AW(TABLE_AW), .IDX_W(IDX_W), .SAMPLE_W(SAMPLE_W)
    ) bus ();

    wavetable_reader #(
        .PHASE_W(PHASE_W), .TABLE_AW(TABLE_AW), .IDX_W(IDX_W),
        .SAMPLE_W(SAMPLE_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ROM: data for a read appears ROM_LAT cycles after rom_rd, garbage otherwise
    logic [15:0] rom_mem [4096];
    logic [15:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= bus.rom_rd ? rom_mem[bus.rom_addr] : 16'($urandom);
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bus.rom_rdata = rom_pipe[ROM_LAT-1];

    logic [11:0] addr_log [$];
    always @(negedge clk) if (reset_n && bus.rom_rd) addr_log.push_back(bus.rom_addr);

    // Reference model state
    logic [23:0] m_phase;
    logic [3:0]  m_table;

    function automatic logic [11:0] m_a0();
        return {m_table, m_phase[23:16]};
    endfunction

    function automatic logic [11:0] m_a1();
        logic [7:0] nxt;
        nxt = m_phase[23:16] + 8'd1;
        return {m_table, nxt};
    endfunction

    function automatic logic [15:0] m_expect();
        int s0, s1, fr, p, q;
        s0 = int'($signed(rom_mem[m_a0()]));
        s1 = int'($signed(rom_mem[m_a1()]));
        fr = int'(m_phase[15:8]);
        p  = (s1 - s0) * fr;
        if (p >= 0) q = p / 256;
        else        q = -((-p + 255) / 256);
        return 16'(s0 + q);
    endfunction

    task automatic m_advance();
        logic [24:0] s;
        s = 25'(m_phase) + 25'(bus.phase_inc);
        m_phase = s[23:0];
        if (s[24]) m_table = bus.table_idx;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        bus.sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        m_phase = '0;
        m_table = '0;
        addr_log.delete();
    endtask

    // Issue one tick at a negedge and wait (bounded) for sample_valid.
    // Returns at the negedge after the valid cycle.
    task automatic run_tick(output int lat, output int bc, output logic [15:0] got,
                            output logic [1:0] tail);
        addr_log.delete();
        bus.sample_tick = 1'b1;
        lat = -1; bc = 0; got = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            bus.sample_tick = 1'b0;
            if (bus.busy) bc++;
            if (bus.sample_valid) begin
                lat = k;
                got = bus.sample_out;
                break;
            end
        end
        @(negedge clk);
        tail = {bus.busy, bus.sample_valid};
    endtask

    task automatic test_reset();
        int lat, bc; logic [15:0] got, exp; logic [1:0] tail; logic [31:0] obs;
        apply_reset();
        n_cmp++; if (bus.sample_out !== 16'h0) begin n_bad++; $display("FAIL rst_sample_out: got %h want 0000", bus.sample_out); end
        n_cmp++; if (bus.sample_valid !== 1'b0) begin n_bad++; $display("FAIL rst_sample_valid: got %b want 0", bus.sample_valid); end
        n_cmp++; if (bus.rom_rd !== 1'b0) begin n_bad++; $display("FAIL rst_rom_rd: got %b want 0", bus.rom_rd); end
        n_cmp++; if (bus.rom_addr !== 12'h0) begin n_bad++; $display("FAIL rst_rom_addr: got %h want 000", bus.rom_addr); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.tick_overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %b want 0", bus.tick_overrun); end
        // reset mid-WAIT1
        bus.table_idx = 4'h0;
        bus.phase_inc = 24'h123456;
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if ({bus.busy, bus.rom_addr} !== {1'b1, 12'h001}) begin n_bad++; $display("FAIL pre_rst_wait1: got busy=%b addr=%h want busy=1 addr=001", bus.busy, bus.rom_addr); end
        reset_n = 1'b0;
        #1;
        obs = {bus.sample_out, bus.sample_valid, bus.rom_rd, bus.rom_addr, bus.busy, bus.tick_overrun};
        n_cmp++; if (obs !== 32'h0) begin n_bad++; $display("FAIL async_rst_outputs: got %h want 00000000", obs); end
        @(negedge clk);
        reset_n = 1'b1;
        m_phase = '0; m_table = '0;
        repeat (2) @(negedge clk);
        exp = m_expect();
        run_tick(lat, bc, got, tail);
        m_advance();
        n_cmp++; if (addr_log.size() == 0 || addr_log[0] !== 12'h000) begin n_bad++; $display("FAIL post_rst_first_addr: got %0d reads, first %h want 000", addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 12'hxxx); end
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL post_rst_sample: got %h want %h", got, exp); end
    endtask

    task automatic test_interp();
        int lat, bc; logic [15:0] got, exp; logic [1:0] tail; logic [11:0] a0, a1;
        logic [15:0] want [2];
        want[0] = 16'h0000; want[1] = 16'h0800;
        apply_reset();
        rom_mem[0] = 16'h0000;
        rom_mem[1] = 16'h1000;
        bus.table_idx = 4'h0;
        bus.phase_inc = 24'h008000;
        for (int t = 0; t < 2; t++) begin
            exp = m_expect(); a0 = m_a0(); a1 = m_a1();
            run_tick(lat, bc, got, tail);
            m_advance();
            n_cmp++; if (got !== want[t]) begin n_bad++; $display("FAIL interp_const[%0d]: got %h want %h", t, got, want[t]); end
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL interp_model[%0d]: got %h want %h", t, got, exp); end
            n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL interp_latency[%0d]: got %0d want 7", t, lat); end
            n_cmp++; if (bc !== 7) begin n_bad++; $display("FAIL interp_busy_cycles[%0d]: got %0d want 7", t, bc); end
            n_cmp++; if (tail !== 2'b00) begin n_bad++; $display("FAIL interp_tail[%0d]: got busy,valid=%b want 00", t, tail); end
            n_cmp++; if (addr_log.size() != 2) begin n_bad++; $display("FAIL interp_nreads[%0d]: got %0d want 2", t, addr_log.size()); end
            else begin
                n_cmp++; if ({addr_log[0], addr_log[1]} !== {a0, a1}) begin n_bad++; $display("FAIL interp_addrs[%0d]: got %h,%h want %h,%h", t, addr_log[0], addr_log[1], a0, a1); end
            end
        end
    endtask

    task automatic test_floor();
        int lat, bc; logic [15:0] got, exp; logic [1:0] tail;
        logic [15:0] want [2];
        want[0] = 16'h7FFF; want[1] = 16'hFFFF;
        rom_mem[1] = 16'h7FFF;
        rom_mem[2] = 16'h8000;
        for (int t = 0; t < 2; t++) begin
            exp = m_expect();
            run_tick(lat, bc, got, tail);
            m_advance();
            n_cmp++; if (got !== want[t]) begin n_bad++; $display("FAIL floor_const[%0d]: got %h want %h", t, got, want[t]); end
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL floor_model[%0d]: got %h want %h", t, got, exp); end
        end
    endtask

    task automatic test_table_wrap();
        int lat, bc; logic [15:0] got, exp; logic [1:0] tail;
        logic [23:0] wa [4];
        wa[0] = {12'h000, 12'h001}; wa[1] = {12'h080, 12'h081};
        wa[2] = {12'h300, 12'h301}; wa[3] = {12'h3FF, 12'h300};
        apply_reset();
        bus.table_idx = 4'h3;
        bus.phase_inc = 24'h800000;
        for (int t = 0; t < 4; t++) begin
            if (t == 2) bus.phase_inc = 24'hFF0000;
            exp = m_expect();
            run_tick(lat, bc, got, tail);
            m_advance();
            n_cmp++; if (addr_log.size() != 2 || {addr_log[0], addr_log[1]} !== wa[t]) begin n_bad++; $display("FAIL wrap_addrs[%0d]: got %0d reads %h want %h", t, addr_log.size(), (addr_log.size() == 2) ? {addr_log[0], addr_log[1]} : 24'hxxxxxx, wa[t]); end
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL wrap_sample[%0d]: got %h want %h", t, got, exp); end
        end
    endtask

    task automatic test_table_switch();
        int lat, bc; logic [15:0] got, exp; logic [1:0] tail;
        logic [11:0] wa [6];
        wa[0] = 12'h000; wa[1] = 12'h010; wa[2] = 12'h050;
        wa[3] = 12'h090; wa[4] = 12'h0D0; wa[5] = 12'h510;
        apply_reset();
        bus.table_idx = 4'h0;
        bus.phase_inc = 24'h100000;
        for (int t = 0; t < 6; t++) begin
            if (t == 1) begin
                bus.table_idx = 4'h5;
                bus.phase_inc = 24'h400000;
            end
            exp = m_expect();
            run_tick(lat, bc, got, tail);
            m_advance();
            n_cmp++; if (addr_log.size() == 0 || addr_log[0] !== wa[t]) begin n_bad++; $display("FAIL switch_addr[%0d]: got %0d reads first %h want %h", t, addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 12'hxxx, wa[t]); end
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL switch_sample[%0d]: got %h want %h", t, got, exp); end
        end
    endtask

    task automatic test_overrun();
        int n_valid, lat2; logic [15:0] got, got2, exp, exp2; logic exp_ov, rd9;
        logic [11:0] addr9, a0n;
        bus.phase_inc = 24'h0123AB;
        exp = m_expect();
        got = '0; rd9 = 1'b0; addr9 = '0; n_valid = 0;
        bus.sample_tick = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp_ov = (k == 4 || k == 8);
            n_cmp++; if (bus.tick_overrun !== exp_ov) begin n_bad++; $display("FAIL overrun_pulse[k=%0d]: got %b want %b", k, bus.tick_overrun, exp_ov); end
            if (bus.sample_valid) begin n_valid++; got = bus.sample_out; end
            if (k == 9) begin rd9 = bus.rom_rd; addr9 = bus.rom_addr; end
            bus.sample_tick = (k == 3 || k == 7 || k == 8);
        end
        m_advance();
        a0n = m_a0();
        exp2 = m_expect();
        n_cmp++; if (n_valid !== 1) begin n_bad++; $display("FAIL overrun_valid_count: got %0d want 1", n_valid); end
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL overrun_sample: got %h want %h", got, exp); end
        n_cmp++; if ({rd9, addr9} !== {1'b1, a0n}) begin n_bad++; $display("FAIL overrun_next_accept: got rd=%b addr=%h want rd=1 addr=%h", rd9, addr9, a0n); end
        lat2 = -1; got2 = '0;
        for (int k = 10; k <= 30; k++) begin
            @(negedge clk);
            if (bus.sample_valid) begin lat2 = k; got2 = bus.sample_out; break; end
        end
        @(negedge clk);
        m_advance();
        n_cmp++; if (lat2 !== 15) begin n_bad++; $display("FAIL overrun_next_latency: got %0d want 15", lat2); end
        n_cmp++; if (got2 !== exp2) begin n_bad++; $display("FAIL overrun_next_sample: got %h want %h", got2, exp2); end
    endtask

    task automatic test_random();
        int lat, bc; logic [15:0] got, exp, frozen; logic [1:0] tail; logic [11:0] a0, a1;
        apply_reset();
        for (int i = 0; i < 4096; i++) rom_mem[i] = 16'($urandom);
        frozen = '0;
        for (int t = 0; t < 40; t++) begin
            bus.table_idx = 4'($urandom);
            if (t == 20 || t == 21) bus.phase_inc = 24'h0;
            else if ($urandom_range(0, 2) == 0) bus.phase_inc = 24'($urandom);
            else bus.phase_inc = 24'($urandom_range(0, 24'h0FFFFF));
            exp = m_expect(); a0 = m_a0(); a1 = m_a1();
            run_tick(lat, bc, got, tail);
            m_advance();
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rand_sample[%0d]: got %h want %h", t, got, exp); end
            n_cmp++; if ({lat, bc} !== {32'd7, 32'd7} || tail !== 2'b00) begin n_bad++; $display("FAIL rand_timing[%0d]: got lat=%0d busy=%0d tail=%b want 7 7 00", t, lat, bc, tail); end
            n_cmp++; if (addr_log.size() != 2 || {addr_log[0], addr_log[1]} !== {a0, a1}) begin n_bad++; $display("FAIL rand_addrs[%0d]: got %0d reads want %h,%h", t, addr_log.size(), a0, a1); end
            if (t == 20) frozen = got;
            if (t == 21) begin
                n_cmp++; if (got !== frozen) begin n_bad++; $display("FAIL rand_freeze: got %h want %h", got, frozen); end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.sample_tick = 1'b0;
        bus.table_idx = '0;
        bus.phase_inc = '0;
        for (int i = 0; i < 4096; i++) rom_mem[i] = 16'($urandom);
        test_reset();
        test_interp();
        test_floor();
        test_table_wrap();
        test_table_switch();
        test_overrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
